// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the mult/div issue stage.
// Holds the FSM state encoding, the status-register index and the exception
// codes (also consumed by the processor's writeback mux), the watchdog limit
// used when MULTDIV_TIMEOUT_EN is defined, and the latched writeback request.
package multdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

  localparam logic [4:0]  RSTATUS_REG    = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE  = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE   = 32'd5;
  localparam int          TIMEOUT_CYCLES = 64;

  // Everything the writeback formatter needs about the in-flight op.
  typedef struct packed {
    logic        is_mult;
    logic        exc;
    logic [4:0]  rd;
    logic [31:0] result;
  } md_wb_req_t;

  function automatic logic [31:0] exc_code(input logic is_mult);
    return is_mult ? MULT_EXC_CODE : DIV_EXC_CODE;
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bundle of the execute-stage request, mult/div unit handshake, stall and
// register-file writeback signals.
//   master : the issue controller (drives md_*, stall, wb_*)
//   slave  : the surrounding pipeline / unit (drives ex_*, md_result*)
interface multdiv_issue_ctrl_if;
  logic        ex_is_mult;
  logic        ex_is_div;
  logic [31:0] ex_opA;
  logic [31:0] ex_opB;
  logic [4:0]  ex_rd;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    input  ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, wb_valid, wb_rd, wb_data
  );

  modport slave (
    output ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_wb_format.sv
// Combinational writeback formatter.
//   req_i      : latched op (type, rd, result, exception)
//   active_i   : controller is in its writeback state
//   wb_valid_o : write enable (suppressed for a normal write to r0)
//   wb_rd_o    : destination (status register on exception)
//   wb_data_o  : result, or zero-extended exception code
module multdiv_wb_format
  import multdiv_issue_ctrl_pkg::*;
(
  input  md_wb_req_t  req_i,
  input  logic        active_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  always_comb begin
    wb_valid_o = 1'b0;
    wb_rd_o    = '0;
    wb_data_o  = '0;
    if (active_i) begin
      if (req_i.exc) begin
        // Exceptions always land in the status register, even for rd=0.
        wb_valid_o = 1'b1;
        wb_rd_o    = RSTATUS_REG;
        wb_data_o  = exc_code(req_i.is_mult);
      end else begin
        wb_valid_o = (req_i.rd != 5'd0);
        wb_rd_o    = req_i.rd;
        wb_data_o  = req_i.result;
      end
    end
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/interlock stage in front of the multiplier/divider.
// Latches a mult/div op, fires a one-cycle start pulse, stalls the pipeline
// until the unit reports ready, then emits one register-file writeback.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : multdiv_issue_ctrl_if.master (ex_*, md_*, stall, wb_*)
// Optional: `define MULTDIV_TIMEOUT_EN adds a WAIT-state watchdog that turns
// a missing ready into an exception writeback after TIMEOUT_CYCLES cycles.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  multdiv_issue_ctrl_if.master  bus
);

  md_state_e   state_q;
  logic [31:0] opa_q, opb_q;
  logic        mult_pulse_q, div_pulse_q;
  md_wb_req_t  req_q;
  logic        start;

  assign start = bus.ex_is_mult | bus.ex_is_div;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      mult_pulse_q <= 1'b0;
      div_pulse_q  <= 1'b0;
      req_q        <= '0;
`ifdef MULTDIV_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      // Start pulses are set on the edge into ISSUE and last one cycle.
      mult_pulse_q <= 1'b0;
      div_pulse_q  <= 1'b0;
      case (state_q)
        // WRITEBACK accepts a new op directly for back-to-back issue.
        ST_IDLE, ST_WB: begin
          if (start) begin
            state_q       <= ST_ISSUE;
            opa_q         <= bus.ex_opA;
            opb_q         <= bus.ex_opB;
            req_q.is_mult <= bus.ex_is_mult;   // mult wins if both set
            req_q.rd      <= bus.ex_rd;
            req_q.exc     <= 1'b0;
            mult_pulse_q  <= bus.ex_is_mult;
            div_pulse_q   <= ~bus.ex_is_mult;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        // Ready here is left over from the previous op, so it is ignored.
        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef MULTDIV_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.md_resultRDY) begin
            state_q      <= ST_WB;
            req_q.result <= bus.md_result;
            req_q.exc    <= bus.md_exception;
          end
`ifdef MULTDIV_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= ST_WB;
            req_q.exc <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.md_operandA  = opa_q;
  assign bus.md_operandB  = opb_q;
  assign bus.md_ctrl_MULT = mult_pulse_q;
  assign bus.md_ctrl_DIV  = div_pulse_q;
  // ISSUE/WAIT always stall; IDLE/WRITEBACK stall only while a new op waits.
  assign bus.stall = (state_q == ST_ISSUE) | (state_q == ST_WAIT) | start;

  multdiv_wb_format u_wb_format (
    .req_i      (req_q),
    .active_i   (state_q == ST_WB),
    .wb_valid_o (bus.wb_valid),
    .wb_rd_o    (bus.wb_rd),
    .wb_data_o  (bus.wb_data)
  );

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multdiv_issue_ctrl_if bus();

  multdiv_issue_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct { logic is_mult; logic [31:0] a; logic [31:0] b; } ctrl_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

  ctrl_t ctrl_q[$];
  wb_t   wb_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every start pulse and every writeback against the queues.
  always @(negedge clock) begin
    if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
      if (ctrl_q.size() == 0) chk("ctrl_unexpected", 1, 0);
      else begin
        ctrl_t c;
        c = ctrl_q.pop_front();
        chk("ctrl_mult", bus.md_ctrl_MULT, c.is_mult);
        chk("ctrl_div", bus.md_ctrl_DIV, !c.is_mult);
        chk("operandA", bus.md_operandA, c.a);
        chk("operandB", bus.md_operandB, c.b);
      end
    end
    if (bus.wb_valid) begin
      if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        wb_t w;
        w = wb_q.pop_front();
        chk("wb_rd", bus.wb_rd, w.rd);
        chk("wb_data", bus.wb_data, w.data);
      end
    end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic at_neg;
    @(negedge clock);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t w;
    w.rd = rd; w.data = data;
    wb_q.push_back(w);
  endtask

  // Present an op for one cycle; on return the DUT is in ISSUE.
  task automatic issue(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    ctrl_t c;
    c.is_mult = m; c.a = a; c.b = b;
    ctrl_q.push_back(c);
    bus.ex_is_mult = m; bus.ex_is_div = d;
    bus.ex_opA = a; bus.ex_opB = b; bus.ex_rd = rd;
    at_neg;
    chk("stall_on_start", bus.stall, 1);
    tick;
    bus.ex_is_mult = 0; bus.ex_is_div = 0;
    bus.ex_opA = 32'hDEAD_BEEF; bus.ex_opB = 32'hCAFE_F00D; bus.ex_rd = 5'd31;
  endtask

  // Unit reports ready for one cycle; on return the DUT is in WRITEBACK.
  task automatic respond(input logic [31:0] res, input logic exc);
    bus.md_result = res; bus.md_exception = exc; bus.md_resultRDY = 1;
    tick;
    bus.md_resultRDY = 0; bus.md_exception = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    bus.ex_is_mult = 0; bus.ex_is_div = 0;
    bus.ex_opA = 0; bus.ex_opB = 0; bus.ex_rd = 0;
    bus.md_result = 0; bus.md_exception = 0; bus.md_resultRDY = 0;
    repeat (3) tick;
    at_neg;
    chk("rst_stall", bus.stall, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_ctrl", {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 0);
    chk("rst_opA", bus.md_operandA, 0);
    chk("rst_opB", bus.md_operandB, 0);
    reset = 0;
    tick;

    // Basic mult, ready 17 cycles after the pulse, operands held in WAIT.
    push_wb(5'd3, 32'd42);
    issue(1, 0, 32'd6, 32'd7, 5'd3);
    repeat (16) tick;
    at_neg;
    chk("wait_stall", bus.stall, 1);
    chk("wait_hold_opA", bus.md_operandA, 32'd6);
    chk("wait_hold_opB", bus.md_operandB, 32'd7);
    chk("wait_no_wb", bus.wb_valid, 0);
    respond(32'd42, 0);
    at_neg;
    chk("mult_wb_valid", bus.wb_valid, 1);
    chk("mult_wb_stall", bus.stall, 0);
    tick;

    // Div exception -> status register gets the div code.
    push_wb(5'd30, 32'd5);
    issue(0, 1, 32'd9, 32'd0, 5'd5);
    repeat (3) tick;
    respond(32'hFFFF_FFFF, 1);
    tick;

    // Mult exception with rd=0 still writes the status register.
    push_wb(5'd30, 32'd4);
    issue(1, 0, 32'd1, 32'd2, 5'd0);
    repeat (2) tick;
    respond(32'd0, 1);
    tick;

    // Both requests high -> mult.
    push_wb(5'd9, 32'd20);
    issue(1, 1, 32'd4, 32'd5, 5'd9);
    tick;
    respond(32'd20, 0);
    tick;

    // Normal write to r0 is suppressed.
    issue(1, 0, 32'd2, 32'd3, 5'd0);
    repeat (2) tick;
    respond(32'd6, 0);
    at_neg;
    chk("rd0_wb_valid", bus.wb_valid, 0);
    chk("rd0_stall", bus.stall, 0);
    tick;

    // Stale ready held through ISSUE must not trigger writeback.
    bus.md_result = 32'd99; bus.md_resultRDY = 1;
    tick;
    push_wb(5'd11, 32'd35);
    issue(0, 1, 32'd70, 32'd2, 5'd11);
    tick;
    bus.md_resultRDY = 0;
    at_neg;
    chk("stale_no_wb", bus.wb_valid, 0);
    chk("stale_stall", bus.stall, 1);
    repeat (2) tick;
    respond(32'd35, 0);
    tick;

    // Back-to-back: div presented during the mult's writeback.
    push_wb(5'd7, 32'd15);
    issue(1, 0, 32'd3, 32'd5, 5'd7);
    tick;
    respond(32'd15, 0);
    push_wb(5'd8, 32'd14);
    issue(0, 1, 32'd100, 32'd7, 5'd8);
    at_neg;
    chk("b2b_div_pulse", bus.md_ctrl_DIV, 1);
    tick;
    respond(32'd14, 0);
    tick;

    // Reset while waiting: result dropped, no pulses, no writeback.
    issue(0, 1, 32'd50, 32'd5, 5'd12);
    repeat (2) tick;
    reset = 1;
    tick;
    reset = 0;
    at_neg;
    chk("rst_wait_stall", bus.stall, 0);
    chk("rst_wait_wb", bus.wb_valid, 0);
    bus.md_result = 32'd10; bus.md_resultRDY = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      at_neg;
      chk("rst_wait_no_ctrl", {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 0);
      chk("rst_wait_no_wb", bus.wb_valid, 0);
    end
    bus.md_resultRDY = 0;
    tick;

`ifdef MULTDIV_TIMEOUT_EN
    // No ready: exception writeback after 64 WAIT cycles, late ready ignored.
    begin
      int n;
      n = 0;
      push_wb(5'd30, 32'd4);
      issue(1, 0, 32'd1, 32'd1, 5'd4);
      while (n < 200) begin
        tick;
        n++;
        at_neg;
        if (bus.wb_valid) break;
      end
      chk("tmo_edges_to_wb", n, 65);
      tick;
      bus.md_result = 32'd77; bus.md_resultRDY = 1;
      repeat (2) tick;
      bus.md_resultRDY = 0;
      tick;
    end
`endif

    repeat (3) tick;
    chk("ctrl_q_empty", ctrl_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
